// File: rtl/crop_norm_pkg.sv
// Shared types and helpers for the crop/normalize Mono8 block.
//   state_e      : frame-control FSM states
//   ProdW        : width of the stage-1 signed product (pixel - MEAN) * GAIN
//   sat_to_width : clamps a product-width value to the signed range of out_w bits
package crop_norm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned ProdW = 18;

  // Result is returned sign-extended to 24 bits; the caller keeps the low out_w bits.
  function automatic logic signed [23:0] sat_to_width(input logic signed [ProdW-1:0] val,
                                                      input int unsigned out_w);
    logic signed [24:0] hi;
    logic signed [24:0] lo;
    logic signed [24:0] x;
    hi = (25'sd1 <<< (out_w - 1)) - 25'sd1;
    lo = -(25'sd1 <<< (out_w - 1));
    x  = {{7{val[ProdW-1]}}, val};
    if (x > hi) begin
      return hi[23:0];
    end else if (x < lo) begin
      return lo[23:0];
    end
    return x[23:0];
  endfunction

endpackage

// File: rtl/norm_stage.sv
// Two-stage normalization pipeline.
//   Stage 1: d = (pixel - MEAN) * GAIN, signed ProdW bits.
//   Stage 2: d >>> GAIN_FRAC, resized to OUT_W bits.
// Optional build macro CROP_NORM_SAT_EN: saturate to the signed OUT_W range instead of
// wrapping to the low OUT_W bits.
// Ports:
//   clk, reset (async, active-high)
//   en_i                   : advance both stages (low = hold everything)
//   in_valid_i/in_data_i/in_last_i : pixel entering stage 1
//   out_valid_o/out_data_o/out_last_o : stage-2 registers, drive the output stream
//   busy_o                 : any stage holds a valid pixel
module norm_stage
  import crop_norm_pkg::*;
#(
  parameter int unsigned MEAN      = 0,
  parameter int unsigned GAIN      = 1,
  parameter int unsigned GAIN_FRAC = 0,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    in_valid_i,
  input  logic [7:0]              in_data_i,
  input  logic                    in_last_i,
  output logic                    out_valid_o,
  output logic signed [OUT_W-1:0] out_data_o,
  output logic                    out_last_o,
  output logic                    busy_o
);

  localparam logic signed [ProdW-1:0] MeanS = ProdW'(MEAN);
  localparam logic signed [ProdW-1:0] GainS = ProdW'(GAIN);

  logic                    s1_valid_q;
  logic                    s1_last_q;
  logic signed [ProdW-1:0] s1_d_q;
  logic signed [ProdW-1:0] s1_d_d;
  logic signed [ProdW-1:0] shifted;
  logic                    s2_valid_q;
  logic                    s2_last_q;
  logic signed [OUT_W-1:0] s2_data_q;
  logic signed [OUT_W-1:0] s2_data_d;

  always_comb begin
    s1_d_d  = ($signed({10'd0, in_data_i}) - MeanS) * GainS;
    shifted = s1_d_q >>> GAIN_FRAC;
`ifdef CROP_NORM_SAT_EN
    s2_data_d = OUT_W'(sat_to_width(shifted, OUT_W));
`else
    s2_data_d = OUT_W'(shifted);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_d_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
    end else if (en_i) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_d_q    <= s1_d_d;
        s1_last_q <= in_last_i;
      end
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_valid_q && s1_last_q;
      // Data only moves with a real pixel so the bus stays quiet between beats.
      if (s1_valid_q) begin
        s2_data_q <= s2_data_d;
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_data_o  = s2_data_q;
  assign out_last_o  = s2_last_q;
  assign busy_o      = s1_valid_q | s2_valid_q;

endmodule

// File: rtl/crop_norm_mono8.sv
// Crop a window out of a Mono8 frame and normalize each kept pixel:
//   out = resize(((pixel - MEAN) * GAIN) >>> GAIN_FRAC, OUT_W)
// Out-of-window pixels are consumed and dropped. Frame control is ap_start/ap_idle/ap_done.
// Optional build macro CROP_NORM_SAT_EN selects saturation (default: two's-complement wrap).
// Ports:
//   clk, reset (async, active-high)
//   ap_start/ap_idle/ap_done            : frame control
//   s_axis_tvalid/tready/tdata          : input pixel stream, cnt_row/cnt_col its coordinates
//   m_axis_tvalid/tready/tdata/tlast    : normalized output stream, tlast on the window's last pixel
module crop_norm_mono8
  import crop_norm_pkg::*;
#(
  parameter int unsigned IN_ROWS   = 20,
  parameter int unsigned IN_COLS   = 20,
  parameter int unsigned CROP_ROW0 = 0,
  parameter int unsigned CROP_COL0 = 0,
  parameter int unsigned CROP_ROWS = 8,
  parameter int unsigned CROP_COLS = 8,
  parameter int unsigned MEAN      = 0,
  parameter int unsigned GAIN      = 1,
  parameter int unsigned GAIN_FRAC = 0,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ap_start,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [7:0]                 s_axis_tdata,
  input  logic [$clog2(IN_COLS)-1:0] cnt_col,
  input  logic [$clog2(IN_ROWS)-1:0] cnt_row,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic signed [OUT_W-1:0]    m_axis_tdata,
  output logic                       m_axis_tlast
);

  state_e      state_q;
  logic        ap_done_q;
  logic        ap_idle_q;
  logic        stall;
  logic        in_hs;
  logic        in_win;
  logic        in_last;
  logic        frame_end;
  logic        busy;
  logic [31:0] row_ext;
  logic [31:0] col_ext;

  always_comb begin
    row_ext = 32'(cnt_row);
    col_ext = 32'(cnt_col);
    stall   = m_axis_tvalid && !m_axis_tready;
    s_axis_tready = (state_q == StRun) && !stall;
    in_hs   = s_axis_tvalid && s_axis_tready;
    // Unsigned wrap makes coordinates below the window origin compare as huge.
    in_win  = ((row_ext - CROP_ROW0) < CROP_ROWS) && ((col_ext - CROP_COL0) < CROP_COLS);
    in_last = (row_ext == CROP_ROW0 + CROP_ROWS - 1) && (col_ext == CROP_COL0 + CROP_COLS - 1);
    frame_end = (row_ext == IN_ROWS - 1) && (col_ext == IN_COLS - 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ap_done_q <= 1'b0;
      ap_idle_q <= 1'b1;
    end else begin
      ap_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ap_start) begin
            state_q   <= StRun;
            ap_idle_q <= 1'b0;
          end
        end
        StRun: begin
          if (in_hs && frame_end) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!busy) begin
            state_q   <= StDone;
            ap_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          ap_idle_q <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          ap_idle_q <= 1'b1;
        end
      endcase
    end
  end

  assign ap_done = ap_done_q;
  assign ap_idle = ap_idle_q;

  norm_stage #(
    .MEAN      (MEAN),
    .GAIN      (GAIN),
    .GAIN_FRAC (GAIN_FRAC),
    .OUT_W     (OUT_W)
  ) u_norm_stage (
    .clk         (clk),
    .reset       (reset),
    .en_i        (!stall),
    .in_valid_i  (in_hs && in_win),
    .in_data_i   (s_axis_tdata),
    .in_last_i   (in_last),
    .out_valid_o (m_axis_tvalid),
    .out_data_o  (m_axis_tdata),
    .out_last_o  (m_axis_tlast),
    .busy_o      (busy)
  );

endmodule
